// File: rtl/ram_reader_pkg.sv
// Shared types and constants for the RAM burst reader: FSM encoding and
// the depth of the output buffer that absorbs RAM read latency.
package ram_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/skid_fifo.sv
// Two-entry buffer between the synchronous RAM read port and the output
// stream; head is presented combinationally and holds until popped.
module skid_fifo
  import ram_reader_pkg::*;
#(
  parameter int RAM_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [RAM_WIDTH-1:0]  push_data,
  input  logic                  pop,
  output logic [RAM_WIDTH-1:0]  head,
  output logic [FIFO_CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [RAM_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 push_ok;
  logic                 pop_ok;

  // Guards keep the pointers consistent even if a caller misbehaves.
  assign push_ok = push && (count < FIFO_CNT_W'(FIFO_DEPTH));
  assign pop_ok  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + FIFO_CNT_W'(push_ok) - FIFO_CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/ram_reader.sv
// Burst reader: walks a synchronous RAM from base_addr for length words
// (optionally looping) and streams the data out through a 2-entry FIFO.
module ram_reader
  import ram_reader_pkg::*;
#(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [RAM_ADDR_BITS-1:0] base_addr,
  input  logic [RAM_ADDR_BITS:0]   length,
  input  logic                     loop_en,
  output logic [RAM_ADDR_BITS-1:0] r_addr,
  input  logic [RAM_WIDTH-1:0]     r_data,
  output logic [RAM_WIDTH-1:0]     m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               dbg_state
);

  localparam int AW = RAM_ADDR_BITS;
  localparam int CW = RAM_ADDR_BITS + 1;

  state_t                state, state_nxt;
  logic [AW-1:0]         base_q;
  logic [CW-1:0]         len_q;
  logic                  loop_q;
  logic [CW-1:0]         issued;
  logic                  in_flight;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  pop;
  logic [2:0]            occ;
  logic                  rd_issue;
  logic                  last_read;
  logic                  drain_empty;
  logic                  accept;
  logic                  done_nxt;

  // Stream handshake: m_valid is high whenever a word is buffered, m_data is
  // held while m_valid && !m_ready, and a word transfers on a rising edge
  // with m_valid && m_ready both high.
  assign m_valid = (fifo_count != '0);
  assign pop     = m_valid && m_ready;

  // Occupancy counts this cycle's pop so a steady stream never bubbles.
  assign occ         = 3'(fifo_count) + 3'(in_flight) - 3'(pop);
  assign last_read   = ((issued + CW'(1)) == len_q);
  assign drain_empty = !in_flight &&
                       ((fifo_count == '0) || ((fifo_count == FIFO_CNT_W'(1)) && pop));
  assign accept      = (state == ST_IDLE) && start && (length != '0);
  assign dbg_state   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_RUN;
      ST_RUN: begin
        if (abort)                                 state_nxt = ST_DRAIN;
        else if (rd_issue && last_read && !loop_q) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (drain_empty) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != ST_IDLE);
    rd_issue = (state == ST_RUN) && !abort && (occ < 3'd2);
    done_nxt = ((state == ST_IDLE) && start && (length == '0)) ||
               ((state == ST_DRAIN) && drain_empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q    <= '0;
      len_q     <= '0;
      loop_q    <= 1'b0;
      issued    <= '0;
      r_addr    <= '0;
      in_flight <= 1'b0;
      done      <= 1'b0;
    end else begin
      in_flight <= rd_issue;
      done      <= done_nxt;
      if (accept) begin
        base_q <= base_addr;
        len_q  <= length;
        loop_q <= loop_en;
        r_addr <= base_addr;
        issued <= '0;
      end else if (rd_issue) begin
        // Looping reloads the base on the final read so the next cycle reads on.
        if (last_read && loop_q) begin
          issued <= '0;
          r_addr <= base_q;
        end else begin
          issued <= issued + CW'(1);
          r_addr <= r_addr + AW'(1);
        end
      end
    end
  end

  skid_fifo #(.RAM_WIDTH(RAM_WIDTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_flight),
    .push_data (r_data),
    .pop       (pop),
    .head      (m_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_ram_reader.sv
// Bench for ram_reader: a RAM model, burst driver tasks, and a monitor that
// checks every streamed word against an expected queue built from the RAM image.
module tb_ram_reader;

  localparam int W     = 8;
  localparam int A     = 4;
  localparam int DEPTH = 1 << A;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         loop_en = 1'b0;
  logic         m_ready = 1'b1;
  logic [A-1:0] base_addr = '0;
  logic [A:0]   length = '0;
  logic [A-1:0] r_addr;
  logic [W-1:0] r_data;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         busy;
  logic         done;
  logic [1:0]   dbg_state;

  logic [W-1:0] ram [DEPTH];
  logic [W-1:0] exp_q[$];

  int  checks = 0;
  int  errors = 0;
  int  xfer_count = 0;
  int  done_count = 0;
  int  valid_count = 0;
  int  cyc = 0;
  int  last_xfer_cyc = 0;
  bit  rnd_ready = 1'b0;
  bit  prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;

  ram_reader #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .length    (length),
    .loop_en   (loop_en),
    .r_addr    (r_addr),
    .r_data    (r_data),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / RAM model ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) r_data <= ram[r_addr];

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = W'(i + 16);
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 32'(m_valid), 32'(1));
          check("stall_data", 32'(m_data), 32'(prev_data));
        end
        if (m_valid) valid_count++;
        if (done) done_count++;
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_word actual=%0h expected=none", m_data);
          end else begin
            check("m_data", 32'(m_data), 32'(exp_q.pop_front()));
          end
          xfer_count++;
          last_xfer_cyc = cyc;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic burst(input int base, input int len, input bit lp,
                       input int abort_after, input bit timing);
    int n0, d0, c, c_first, got;
    n0 = xfer_count;
    d0 = done_count;
    c_first = 0;
    if (lp) for (int i = 0; i < 64; i++) exp_q.push_back(ram[A'((base + i % len) % DEPTH)]);
    else    for (int i = 0; i < len; i++) exp_q.push_back(ram[A'((base + i) % DEPTH)]);
    start = 1'b1; base_addr = A'(base); length = (A+1)'(len); loop_en = lp;
    tick();
    start = 1'b0; base_addr = A'($urandom); length = (A+1)'($urandom_range(0, 16)); loop_en = ~lp;
    if (timing) begin
      for (int k = 0; k < 4; k++) begin
        if (k < len) check("r_addr_seq", 32'(r_addr), 32'((base + k) % DEPTH));
        check("m_valid_latency", 32'(m_valid), 32'(k >= 2));
        if (k == 2) c_first = cyc;
        tick();
      end
    end else if (len >= 8 && !lp) begin
      repeat (3) tick();
      start = 1'b1; base_addr = A'(base + 5); length = (A+1)'(3);
      tick();
      start = 1'b0;
    end
    if (abort_after > 0) begin
      c = 0;
      while ((xfer_count - n0) < abort_after && c < 2000) begin tick(); c++; end
      check("abort_wait_timeout", 32'(c < 2000), 32'(1));
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    c = 0;
    while (busy && c < 2000) begin tick(); c++; end
    check("idle_timeout", 32'(c < 2000), 32'(1));
    tick();
    got = xfer_count - n0;
    check("done_pulses", 32'(done_count - d0), 32'(1));
    if (abort_after == 0) begin
      check("word_count", 32'(got), 32'(len));
      check("queue_empty", 32'(exp_q.size()), 32'(0));
      if (timing) check("throughput", 32'(last_xfer_cyc - c_first), 32'(len - 1));
    end else begin
      check("abort_words", 32'(got >= abort_after && got <= abort_after + 2 && (lp || got <= len)), 32'(1));
      exp_q.delete();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0, v0, x0, len, ab;
    bit lp;
    repeat (3) @(posedge clk);
    #1;
    check("rst_r_addr", 32'(r_addr), 32'(0));
    check("rst_m_valid", 32'(m_valid), 32'(0));
    check("rst_m_data", 32'(m_data), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_state", 32'(dbg_state), 32'(0));
    rst_n = 1'b1;
    tick();

    burst(3, 4, 1'b0, 0, 1'b1);
    burst(14, 4, 1'b0, 0, 1'b1);
    burst(13, 16, 1'b0, 0, 1'b1);

    rnd_ready = 1'b1;
    burst(int'($urandom_range(0, DEPTH - 1)), 16, 1'b0, 0, 1'b0);
    rnd_ready = 1'b0;
    burst(0, 2, 1'b1, 5, 1'b0);

    // zero-length request
    d0 = done_count; v0 = valid_count; x0 = xfer_count;
    start = 1'b1; length = '0; base_addr = 4'd7;
    tick();
    start = 1'b0;
    check("len0_done", 32'(done), 32'(1));
    check("len0_busy", 32'(busy), 32'(0));
    check("len0_state", 32'(dbg_state), 32'(0));
    tick();
    check("len0_done_fall", 32'(done), 32'(0));
    repeat (4) tick();
    check("len0_done_count", 32'(done_count - d0), 32'(1));
    check("len0_no_valid", 32'(valid_count - v0), 32'(0));

    // abort while idle
    d0 = done_count;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_state", 32'(dbg_state), 32'(0));
    tick();
    check("idle_abort_done", 32'(done_count - d0), 32'(0));

    // reset in the middle of a burst
    for (int i = 0; i < 16; i++) exp_q.push_back(ram[A'((5 + i) % DEPTH)]);
    start = 1'b1; base_addr = 4'd5; length = 5'd16; loop_en = 1'b0;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_m_valid", 32'(m_valid), 32'(0));
    check("midrst_m_data", 32'(m_data), 32'(0));
    check("midrst_r_addr", 32'(r_addr), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    check("midrst_state", 32'(dbg_state), 32'(0));
    exp_q.delete();
    d0 = done_count; v0 = valid_count;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("midrst_no_done", 32'(done_count - d0), 32'(0));
    check("midrst_no_stale", 32'(valid_count - v0), 32'(0));

    // randomized bursts
    for (int t = 0; t < 12; t++) begin
      len = int'($urandom_range(1, DEPTH));
      lp = 1'($urandom_range(0, 2) == 0);
      rnd_ready = 1'($urandom_range(0, 1));
      if (lp) ab = int'($urandom_range(1, 20));
      else if (len >= 2 && $urandom_range(0, 2) == 0) ab = int'($urandom_range(1, len - 1));
      else ab = 0;
      burst(int'($urandom_range(0, DEPTH - 1)), len, lp, ab, 1'b0);
    end
    rnd_ready = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
